fetch_stage: RTL and testbench

//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC, issues one

---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid fetch,
// and holds the fetched word for decode. Redirects drop any fetch still in flight.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] pcplus4F,
  output logic        validF
);

  // state  | meaning
  // S_REQ  | request for pc presented, waiting for gnt
  // S_WAIT | request accepted, waiting for rvalid (kill_q drops the data)
  // S_HOLD | instruction held in instr_q until decode takes it
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    if (redirect) begin
      pc_d = redirect_tgt;
      unique case (state_q)
        S_REQ: begin
          // An accepted old-PC request still owes us a response; drop it when it lands.
          if (imem_gnt) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              instr_d = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (en) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req  = (state_q == S_REQ) & reset_n;
  assign imem_addr = pc_q;
  assign pcF       = pc_q;
  assign pcplus4F  = pc_q + 32'd4;
  assign validF    = (state_q == S_HOLD);
  assign instrF    = validF ? instr_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-in-flight sequence, then random
// traffic checked against a program-order model with a latency-randomised memory.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0, redirect = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, validF;
  logic [31:0] imem_addr, instrF, pcF, pcplus4F;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrF(instrF), .pcF(pcF), .pcplus4F(pcplus4F), .validF(validF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, gnt, rvalid, redir;
    logic [31:0] rdata, rpc;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_instr, e_pc;
  } vec_t;

  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, g, rv, rd, input logic [31:0] rdat, rpc,
                              input logic x_req, x_val, input logic [31:0] x_addr, x_instr, x_pc);
    vec_t v;
    v.en = e; v.gnt = g; v.rvalid = rv; v.redir = rd; v.rdata = rdat; v.rpc = rpc;
    v.e_req = x_req; v.e_valid = x_val; v.e_addr = x_addr; v.e_instr = x_instr; v.e_pc = x_pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // random-phase model state
  logic [31:0] arch_pc, mem_a;
  logic        pend, redir_prev, hold_prev, s_valid, s_req;
  logic [31:0] s_addr;
  int          lat, delivered;

  initial begin
    //            en gnt rv rd rdata          rpc            req val addr           instr          pc
    vec[0]  = mk(0, 1, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0,         NOP,           32'h0);
    vec[1]  = mk(0, 0, 1, 0, 32'h0020_0093, 32'h0,         0, 0, 32'h0,         NOP,           32'h0);
    vec[2]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0020_0093, 32'h0);
    vec[3]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0020_0093, 32'h0);
    vec[4]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0020_0093, 32'h0);
    vec[5]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0020_0093, 32'h0);
    vec[6]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0020_0093, 32'h0);
    vec[7]  = mk(1, 0, 0, 0, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0020_0093, 32'h0);
    vec[8]  = mk(0, 0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h4,         NOP,           32'h4);
    vec[9]  = mk(0, 1, 0, 0, 32'h0,         32'h0,         1, 0, 32'h4,         NOP,           32'h4);
    vec[10] = mk(0, 0, 0, 1, 32'h0,         32'h0000_0103, 0, 0, 32'h4,         NOP,           32'h4);
    vec[11] = mk(0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h100,       NOP,           32'h100);
    vec[12] = mk(1, 0, 1, 0, 32'hDEAD_BEEF, 32'h0,         0, 0, 32'h100,       NOP,           32'h100);
    vec[13] = mk(1, 1, 0, 0, 32'h0,         32'h0,         1, 0, 32'h100,       NOP,           32'h100);
    vec[14] = mk(0, 0, 1, 0, 32'h1111_1111, 32'h0,         0, 0, 32'h100,       NOP,           32'h100);
    vec[15] = mk(1, 0, 0, 1, 32'h0,         32'hFFFF_FFFE, 0, 1, 32'h100,       32'h1111_1111, 32'h100);
    vec[16] = mk(1, 1, 0, 0, 32'h0,         32'h0,         1, 0, 32'hFFFF_FFFC, NOP,           32'hFFFF_FFFC);
    vec[17] = mk(0, 0, 1, 0, 32'h2222_2222, 32'h0,         0, 0, 32'hFFFF_FFFC, NOP,           32'hFFFF_FFFC);
    vec[18] = mk(1, 0, 0, 0, 32'h0,         32'h0,         0, 1, 32'hFFFF_FFFC, 32'h2222_2222, 32'hFFFF_FFFC);
    vec[19] = mk(0, 0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h0,         NOP,           32'h0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", validF, 1'b0);
    chk("rst_instr", instrF, NOP);
    chk("rst_pc", pcF, 32'h0);
    chk("rst_pc4", pcplus4F, 32'h4);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req", i), imem_req, vec[i].e_req);
      chk($sformatf("v%0d_valid", i), validF, vec[i].e_valid);
      chk($sformatf("v%0d_addr", i), imem_addr, vec[i].e_addr);
      chk($sformatf("v%0d_instr", i), instrF, vec[i].e_instr);
      chk($sformatf("v%0d_pc", i), pcF, vec[i].e_pc);
      chk($sformatf("v%0d_pc4", i), pcplus4F, vec[i].e_pc + 32'd4);
      en = vec[i].en; imem_gnt = vec[i].gnt; imem_rvalid = vec[i].rvalid;
      redirect = vec[i].redir; imem_rdata = vec[i].rdata; redirect_pc = vec[i].rpc;
    end

    // reset while a fetch is outstanding; the stale response must be ignored
    @(negedge clk);
    en = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
    chk("r6_req", imem_req, 1'b1);
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("r6_wait", imem_req, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("r6_rst_req", imem_req, 1'b0);
    chk("r6_rst_valid", validF, 1'b0);
    chk("r6_rst_pc", pcF, 32'h0);
    @(negedge clk);
    reset_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("r6_req_after", imem_req, 1'b1);
    chk("r6_addr_after", imem_addr, 32'h0);
    chk("r6_valid_after", validF, 1'b0);
    chk("r6_instr_after", instrF, NOP);

    // random traffic against a program-order model
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    arch_pc = 32'h0; pend = 1'b0; lat = 0; mem_a = '0;
    redir_prev = 1'b0; hold_prev = 1'b0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_valid = validF; s_req = imem_req; s_addr = imem_addr;
      chk("rnd_pc", pcF, arch_pc);
      chk("rnd_pc4", pcplus4F, arch_pc + 32'd4);
      if (s_valid) chk("rnd_instr", instrF, mem_word(arch_pc));
      else         chk("rnd_nop", instrF, NOP);
      if (s_req) chk("rnd_addr", s_addr, arch_pc);
      if (redir_prev) chk("rnd_bubble", validF, 1'b0);
      if (hold_prev)  chk("rnd_hold", validF, 1'b1);
      imem_gnt    = s_req && ($urandom_range(0, 1) == 1);
      imem_rvalid = pend && (lat == 0);
      imem_rdata  = imem_rvalid ? mem_word(mem_a) : $urandom;
      en          = ($urandom_range(0, 1) == 1);
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      @(posedge clk);
      hold_prev  = s_valid && !en && !redirect;
      redir_prev = redirect;
      if (redirect) arch_pc = {redirect_pc[31:2], 2'b00};
      else if (s_valid && en) begin
        arch_pc = arch_pc + 32'd4;
        delivered++;
      end
      if (imem_rvalid) pend = 1'b0;
      else if (pend) lat--;
      if (s_req && imem_gnt) begin
        pend = 1'b1; mem_a = s_addr; lat = $urandom_range(0, 2);
      end
    end
    chk("rnd_progress", (delivered > 50) ? 32'd1 : 32'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
